// File: rtl/counter_pkg.sv
// Shared types and helpers for the modulo-N up/down counter.
// Holds the command encoding and the elaboration-time width helpers.
package counter_pkg;

    localparam int TERM_DN = 0;

    // Lower value = higher priority; the top module resolves controls into one command.
    typedef enum logic [1:0] {
        CMD_CLR  = 2'd0,
        CMD_LOAD = 2'd1,
        CMD_CNT  = 2'd2,
        CMD_HOLD = 2'd3
    } cnt_cmd_t;

    // Number of bits needed to represent 0..value-1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    function automatic int term_up(input int modulus);
        return modulus - 1;
    endfunction

endpackage

// File: rtl/counter_reg.sv
// W-bit D register with asynchronous active-low reset to RESET_VAL.
// Used for both the count value and the one-bit wrap flag.
module counter_reg #(
    parameter int         W         = 1,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic [W-1:0] D,
    output logic [W-1:0] Q
);

    // NOTE: sequential state uses non-blocking assignment so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Q <= RESET_VAL;
        end else begin
            Q <= D;
        end
    end

endmodule

// File: rtl/counter_mod_updown.sv
// Parametrised modulo-N up/down counter with load, sync clear, combinational CO and registered WRAP.
// Define COUNTER_SATURATE_EN to hold at the terminal value (WRAP then flags the blocked step).
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MODULUS   = 16,
    parameter int RESET_VAL = 0
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             CLR,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D,
    input  logic             EN,
    input  logic             UP,
    output logic [WIDTH-1:0] Q,
    output logic             CO,
    output logic             WRAP
);

    if (WIDTH < 1 || MODULUS < 2 || clog2(MODULUS) > WIDTH) begin : g_bad_modulus
        $error("counter_mod_updown: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MODULUS) begin : g_bad_reset_val
        $error("counter_mod_updown: RESET_VAL must be below MODULUS");
    end

    localparam logic [WIDTH-1:0] TERM_UP = WIDTH'(term_up(MODULUS));
    localparam logic [WIDTH-1:0] TERM_LO = WIDTH'(TERM_DN);
    // One extra bit so MODULUS == 2**WIDTH is representable in range compares.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    cnt_cmd_t         cmd;
    logic             at_up, at_dn, d_in_range, q_oob;

    assign at_up      = (q_q == TERM_UP);
    assign at_dn      = (q_q == TERM_LO);
    assign d_in_range = ({1'b0, D} < MOD_EXT);
    assign q_oob      = ({1'b0, q_q} >= MOD_EXT);

    always_comb begin
        if (CLR) begin
            cmd = CMD_CLR;
        end else if (LOAD) begin
            cmd = CMD_LOAD;
        end else if (EN) begin
            cmd = CMD_CNT;
        end else begin
            cmd = CMD_HOLD;
        end
    end

    // NOTE: every output gets a default first, so no path through the case can infer a latch.
    always_comb begin
        q_d    = q_q;
        wrap_d = 1'b0;
        unique case (cmd)
            CMD_CLR:  q_d = '0;
            CMD_LOAD: q_d = d_in_range ? D : '0;
            CMD_CNT: begin
                if (q_oob) begin
                    q_d = '0;
                end else if (UP) begin
                    wrap_d = at_up;
`ifdef COUNTER_SATURATE_EN
                    q_d = at_up ? q_q : q_q + WIDTH'(1);
`else
                    q_d = at_up ? '0 : q_q + WIDTH'(1);
`endif
                end else begin
                    wrap_d = at_dn;
`ifdef COUNTER_SATURATE_EN
                    q_d = at_dn ? q_q : q_q - WIDTH'(1);
`else
                    q_d = at_dn ? TERM_UP : q_q - WIDTH'(1);
`endif
                end
            end
            CMD_HOLD: q_d = q_q;
            default:  q_d = q_q;
        endcase
    end

    counter_reg #(
        .W         (WIDTH),
        .RESET_VAL (WIDTH'(RESET_VAL))
    ) u_q_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (q_d),
        .Q     (q_q)
    );

    counter_reg #(
        .W         (1),
        .RESET_VAL (1'b0)
    ) u_wrap_reg (
        .CLK   (CLK),
        .RESET (RESET),
        .D     (wrap_d),
        .Q     (wrap_q)
    );

    // No register stage on CO: it must enable the next digit on the very edge this one wraps.
    assign CO   = EN & ~CLR & ~LOAD & (UP ? at_up : at_dn);
    assign Q    = q_q;
    assign WRAP = wrap_q;

endmodule
